// File: rtl/mem_stage.sv
// MIPS MEM stage: little-endian byte-enable data memory, extended loads,
// and the MEM/WB pipeline register advanced by i_step.
module mem_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_step,
  input  logic               i_mem2reg,
  input  logic               i_memWrite,
  input  logic               i_regWrite,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic [4:0]         i_write_reg,
  input  logic [NB_DATA-1:0] i_result,
  input  logic [NB_DATA-1:0] i_data4Mem,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic               o_mem2reg,
  output logic               o_regWrite,
  output logic [4:0]         o_write_reg,
  output logic [NB_DATA-1:0] o_read_data,
  output logic [NB_DATA-1:0] o_result,
  output logic [NB_DATA-1:0] o_dbg_data
);
  localparam int NB_LANE = NB_DATA / 8;
  localparam int DEPTH   = 1 << NB_ADDR;

  logic [NB_ADDR-1:0] widx;
  logic [1:0]         lane;
  logic               wr_en;
  logic [NB_LANE-1:0] be;
  logic [NB_DATA-1:0] wdata, rd_word, dbg_word, load_ext;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;

  // Upper address bits are dropped on purpose: accesses wrap modulo memory size.
  assign widx  = i_result[NB_ADDR+1:2];
  assign lane  = i_result[1:0];
  assign wr_en = i_step & i_memWrite;

  always_comb begin
    be    = '0;
    wdata = i_data4Mem;
    case (i_width)
      2'b00: begin
        be[lane] = 1'b1;
        wdata    = {NB_LANE{i_data4Mem[7:0]}};
      end
      2'b01: begin
        be    = i_result[1] ? NB_LANE'(4'b1100) : NB_LANE'(4'b0011);
        wdata = {(NB_LANE/2){i_data4Mem[15:0]}};
      end
      default: be = '1;
    endcase
  end

  // One byte-wide array per lane so byte enables map to independent writes.
  for (genvar g = 0; g < NB_LANE; g++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (i_reset) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en && be[g]) begin
        mem[widx] <= wdata[8*g +: 8];
      end
    end

    assign rd_word[8*g +: 8]  = mem[widx];
    assign dbg_word[8*g +: 8] = mem[i_dbg_addr];
  end

  assign byte_sel   = rd_word[{lane, 3'b000} +: 8];
  assign half_sel   = i_result[1] ? rd_word[31:16] : rd_word[15:0];
  assign o_dbg_data = dbg_word;

  always_comb begin
    case (i_width)
      2'b00:   load_ext = {{(NB_DATA-8){i_sign_flag & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{(NB_DATA-16){i_sign_flag & half_sel[15]}}, half_sel};
      default: load_ext = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_mem2reg   <= 1'b0;
      o_regWrite  <= 1'b0;
      o_write_reg <= '0;
      o_read_data <= '0;
      o_result    <= '0;
    end else if (i_step) begin
      o_mem2reg   <= i_mem2reg;
      o_regWrite  <= i_regWrite;
      o_write_reg <= i_write_reg;
      o_read_data <= load_ext;
      o_result    <= i_result;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; MEM/WB expectations queued per step and
// compared one edge later.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        i_reset, i_step, i_mem2reg, i_memWrite, i_regWrite, i_sign_flag;
  logic [1:0]  i_width;
  logic [4:0]  i_write_reg;
  logic [31:0] i_result, i_data4Mem;
  logic [6:0]  i_dbg_addr;
  logic        o_mem2reg, o_regWrite;
  logic [4:0]  o_write_reg;
  logic [31:0] o_read_data, o_result, o_dbg_data;

  mem_stage #(.NB_DATA(32), .NB_ADDR(7)) dut (
    .clk(clk), .i_reset(i_reset), .i_step(i_step), .i_mem2reg(i_mem2reg),
    .i_memWrite(i_memWrite), .i_regWrite(i_regWrite), .i_width(i_width),
    .i_sign_flag(i_sign_flag), .i_write_reg(i_write_reg), .i_result(i_result),
    .i_data4Mem(i_data4Mem), .i_dbg_addr(i_dbg_addr), .o_mem2reg(o_mem2reg),
    .o_regWrite(o_regWrite), .o_write_reg(o_write_reg), .o_read_data(o_read_data),
    .o_result(o_result), .o_dbg_data(o_dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        m2r;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] rd;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_mem2reg"},   {31'd0, o_mem2reg},  {31'd0, e.m2r});
      chk({tag, "_regWrite"},  {31'd0, o_regWrite}, {31'd0, e.rw});
      chk({tag, "_write_reg"}, {27'd0, o_write_reg}, {27'd0, e.wr});
      chk({tag, "_read_data"}, o_read_data, e.rd);
      chk({tag, "_result"},    o_result, e.res);
      last = e;
    end
  endtask

  // One stepped instruction: drive, queue expectation, clock, compare.
  task automatic op(input string tag, input logic m2r, input logic mw, input logic rw,
                    input logic [1:0] w, input logic sg, input logic [4:0] wr,
                    input logic [31:0] res, input logic [31:0] dat, input logic [31:0] exp_rd);
    i_mem2reg = m2r; i_memWrite = mw; i_regWrite = rw; i_width = w;
    i_sign_flag = sg; i_write_reg = wr; i_result = res; i_data4Mem = dat;
    i_step = 1'b1;
    sb.push_back('{m2r, rw, wr, exp_rd, res});
    @(posedge clk); #1;
    i_step = 1'b0;
    check_out(tag);
  endtask

  task automatic dbg(input string tag, input logic [6:0] idx, input logic [31:0] exp);
    i_dbg_addr = idx;
    #1;
    chk(tag, o_dbg_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset = 1'b1; i_step = 1'b1; i_mem2reg = 1'b0; i_memWrite = 1'b1;
    i_regWrite = 1'b1; i_width = 2'b10; i_sign_flag = 1'b0; i_write_reg = 5'd9;
    i_result = 32'h0; i_data4Mem = 32'hFFFF_FFFF; i_dbg_addr = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem2reg",   {31'd0, o_mem2reg},  32'd0);
    chk("rst_regWrite",  {31'd0, o_regWrite}, 32'd0);
    chk("rst_write_reg", {27'd0, o_write_reg}, 32'd0);
    chk("rst_read_data", o_read_data, 32'd0);
    chk("rst_result",    o_result, 32'd0);
    dbg("rst_dbg0", 7'd0, 32'd0);
    i_reset = 1'b0; i_step = 1'b0; i_memWrite = 1'b0;

    op("st_word",  0, 1, 0, 2'b10, 0, 5'd0, 32'h10, 32'hDEADBEEF, 32'h0);
    dbg("dbg_w4", 7'd4, 32'hDEADBEEF);
    op("ld_word",  1, 0, 1, 2'b10, 0, 5'd3, 32'h10, 32'h0, 32'hDEADBEEF);
    op("ld_b13_s", 1, 0, 1, 2'b00, 1, 5'd4, 32'h13, 32'h0, 32'hFFFFFFDE);
    op("ld_b13_u", 1, 0, 1, 2'b00, 0, 5'd5, 32'h13, 32'h0, 32'h000000DE);
    op("ld_b10_s", 1, 0, 1, 2'b00, 1, 5'd6, 32'h10, 32'h0, 32'hFFFFFFEF);

    // Store reads return the pre-write contents of the addressed field.
    op("st_byte",  0, 1, 0, 2'b00, 0, 5'd0, 32'h11, 32'hAABBCC55, 32'h000000BE);
    dbg("dbg_byte", 7'd4, 32'hDEAD55EF);
    op("st_half",  0, 1, 0, 2'b01, 0, 5'd0, 32'h12, 32'h99991234, 32'h0000DEAD);
    dbg("dbg_half", 7'd4, 32'h123455EF);
    op("ld_h12_u", 1, 0, 1, 2'b01, 0, 5'd8, 32'h12, 32'h0, 32'h00001234);
    op("ld_h11_s", 1, 0, 1, 2'b01, 1, 5'd8, 32'h11, 32'h0, 32'h000055EF);
    op("ld_h12_s", 1, 0, 1, 2'b01, 1, 5'd8, 32'h13, 32'h0, 32'h00001234);

    // Stall: pending store held off by i_step=0.
    i_mem2reg = 1'b0; i_memWrite = 1'b1; i_regWrite = 1'b0; i_width = 2'b10;
    i_sign_flag = 1'b0; i_write_reg = 5'd2; i_result = 32'h20; i_data4Mem = 32'h1;
    i_step = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      dbg("stall_dbg8", 7'd8, 32'h0);
      chk("stall_result", o_result, last.res);
      chk("stall_read",   o_read_data, last.rd);
      chk("stall_wreg",   {27'd0, o_write_reg}, {27'd0, last.wr});
    end
    op("stall_go", 0, 1, 0, 2'b10, 0, 5'd2, 32'h20, 32'h1, 32'h0);
    dbg("dbg_w8", 7'd8, 32'h1);

    op("pass_thru", 0, 0, 1, 2'b10, 0, 5'd7, 32'h200, 32'h0, 32'h0);
    op("st_wrap",   0, 1, 0, 2'b10, 0, 5'd0, 32'h200, 32'hCAFEF00D, 32'h0);
    dbg("dbg_wrap0", 7'd0, 32'hCAFEF00D);
    op("ld_w0",     1, 0, 1, 2'b10, 0, 5'd1, 32'h0, 32'h0, 32'hCAFEF00D);

    op("ld_st_both", 1, 1, 1, 2'b10, 0, 5'd9, 32'h20, 32'h77, 32'h1);
    dbg("dbg_both", 7'd8, 32'h77);

    // Reset mid-stream discards the coincident store and clears memory.
    i_reset = 1'b1; i_step = 1'b1; i_memWrite = 1'b1; i_width = 2'b10;
    i_result = 32'h10; i_data4Mem = 32'h5A5A5A5A;
    @(posedge clk); #1;
    i_reset = 1'b0; i_step = 1'b0; i_memWrite = 1'b0;
    chk("rst2_result", o_result, 32'd0);
    chk("rst2_read",   o_read_data, 32'd0);
    dbg("rst2_dbg4", 7'd4, 32'h0);
    dbg("rst2_dbg0", 7'd0, 32'h0);
    op("rst2_ld", 1, 0, 1, 2'b10, 0, 5'd3, 32'h10, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
